decode_stage: RTL and testbench

- Decode stage of the 5-stage pipelined processor, ending in the decode/execute (DE) pipeline register.
- Takes the 16-bit instruction from the FD register and generates the 11-bit control word.
- Reads two operands from an internal 8x16 register file, which the writeback stage writes.
- Registers control, operands, destination address and function code for the execute stage.

---
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: turns the FD instruction into a control word, reads two
// operands from the 8-entry register file (written by writeback) and
// registers everything into the decode/execute (DE) pipeline register.
module decode_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           instruction,
  input  logic                  write_enable,
  input  logic [2:0]            write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [10:0]           control_signals_out,
  output logic [DATA_WIDTH-1:0] read_data1_out,
  output logic [DATA_WIDTH-1:0] read_data2_out,
  output logic [2:0]            write_add_out,
  output logic [2:0]            function_out
);

  typedef enum logic [2:0] {
    TYPE_NOP    = 3'b000,
    TYPE_ALUREG = 3'b001,
    TYPE_ALUIMM = 3'b010,
    TYPE_LOAD   = 3'b011,
    TYPE_STORE  = 3'b100,
    TYPE_BRANCH = 3'b101,
    TYPE_IO     = 3'b110,
    TYPE_STACK  = 3'b111
  } instrType_e;

  // Control word bit positions
  localparam int MEM_WRITE = 10;
  localparam int MEM_READ  = 9;
  localparam int MEM_TO_REG = 8;
  localparam int REG_WRITE = 7;
  localparam int BRANCH    = 6;
  localparam int IN_BIT    = 5;
  localparam int OUT_BIT   = 4;
  localparam int STACK_OP  = 3;
  localparam int PUSH      = 2;
  localparam int ALU_SRC   = 1;
  localparam int ALU_OP    = 0;

  instrType_e instrType;
  logic [2:0] rsrc1;
  logic [2:0] rdst;
  logic [2:0] rsrc2;
  logic [2:0] func;
  logic       unusedBit;

  assign instrType = instrType_e'(instruction[15:13]);
  assign rsrc1     = instruction[12:10];
  assign rdst      = instruction[9:7];
  assign rsrc2     = instruction[6:4];
  assign func      = instruction[2:0];
  assign unusedBit = instruction[3];

  logic [10:0]           controlWord;
  logic [DATA_WIDTH-1:0] regFile [8];
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;

  // Combinational decode of the instruction type into the control word
  always_comb begin
    controlWord = '0;
    unique case (instrType)
      TYPE_NOP: ;
      TYPE_ALUREG: begin
        controlWord[REG_WRITE] = 1'b1;
        controlWord[ALU_OP]    = 1'b1;
      end
      TYPE_ALUIMM: begin
        controlWord[REG_WRITE] = 1'b1;
        controlWord[ALU_OP]    = 1'b1;
        controlWord[ALU_SRC]   = 1'b1;
      end
      TYPE_LOAD: begin
        controlWord[MEM_READ]   = 1'b1;
        controlWord[MEM_TO_REG] = 1'b1;
        controlWord[REG_WRITE]  = 1'b1;
        controlWord[ALU_SRC]    = 1'b1;
      end
      TYPE_STORE: begin
        controlWord[MEM_WRITE] = 1'b1;
        controlWord[ALU_SRC]   = 1'b1;
      end
      TYPE_BRANCH: begin
        controlWord[BRANCH] = 1'b1;
      end
      TYPE_IO: begin
        if (func[0]) begin
          controlWord[OUT_BIT] = 1'b1;
        end else begin
          controlWord[IN_BIT]    = 1'b1;
          controlWord[REG_WRITE] = 1'b1;
        end
      end
      TYPE_STACK: begin
        controlWord[STACK_OP] = 1'b1;
        if (func[0]) begin
          controlWord[MEM_READ]   = 1'b1;
          controlWord[MEM_TO_REG] = 1'b1;
          controlWord[REG_WRITE]  = 1'b1;
        end else begin
          controlWord[PUSH]      = 1'b1;
          controlWord[MEM_WRITE] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Register file write port; R0 is an ordinary writable register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regFile[i] <= '0;
      end
    end else if (write_enable) begin
      regFile[write_address] <= write_data;
    end
  end

  // Read ports with write-through so a same-cycle writeback is seen
  always_comb begin
    readData1 = regFile[rsrc1];
    readData2 = regFile[rsrc2];
    if (write_enable && (write_address == rsrc1)) begin
      readData1 = write_data;
    end
    if (write_enable && (write_address == rsrc2)) begin
      readData2 = write_data;
    end
  end

  // DE pipeline register: flush inserts a bubble in control only, stall holds all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      control_signals_out <= '0;
      read_data1_out      <= '0;
      read_data2_out      <= '0;
      write_add_out       <= '0;
      function_out        <= '0;
    end else if (flush) begin
      control_signals_out <= '0;
      read_data1_out      <= readData1;
      read_data2_out      <= readData2;
      write_add_out       <= rdst;
      function_out        <= func;
    end else if (!stall) begin
      control_signals_out <= controlWord;
      read_data1_out      <= readData1;
      read_data2_out      <= readData2;
      write_add_out       <= rdst;
      function_out        <= func;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        writeEnable;
  logic [2:0]  writeAddress;
  logic [15:0] writeData;
  logic        stall;
  logic        flush;
  logic [10:0] controlOut;
  logic [15:0] readData1Out;
  logic [15:0] readData2Out;
  logic [2:0]  writeAddOut;
  logic [2:0]  functionOut;

  int checkCount = 0;
  int errorCount = 0;

  decode_stage #(.DATA_WIDTH(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction         (instruction),
    .write_enable        (writeEnable),
    .write_address       (writeAddress),
    .write_data          (writeData),
    .stall               (stall),
    .flush               (flush),
    .control_signals_out (controlOut),
    .read_data1_out      (readData1Out),
    .read_data2_out      (readData2Out),
    .write_add_out       (writeAddOut),
    .function_out        (functionOut)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mkInstr(input logic [2:0] t, input logic [2:0] rs1,
                                          input logic [2:0] rd, input logic [2:0] rs2,
                                          input logic [2:0] fn);
    return {t, rs1, rd, rs2, 1'b0, fn};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and land 1 ns after the edge
  task automatic applyStimulus(input logic [15:0] instr, input logic we,
                               input logic [2:0] wa, input logic [15:0] wd,
                               input logic st, input logic fl);
    instruction  = instr;
    writeEnable  = we;
    writeAddress = wa;
    writeData    = wd;
    stall        = st;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  sweepType [10];
  logic [2:0]  sweepFunc [10];
  logic [10:0] sweepCtrl [10];

  initial begin
    sweepType = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    sweepFunc = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1};
    sweepCtrl = '{11'h000, 11'h081, 11'h083, 11'h382, 11'h402,
                  11'h040, 11'h0A0, 11'h010, 11'h40C, 11'h388};

    reset = 1'b0; instruction = '0; writeEnable = 1'b0; writeAddress = '0;
    writeData = '0; stall = 1'b0; flush = 1'b0;
    #12;
    checkOutput("resetCtrl", 32'(controlOut), 32'h000);
    checkOutput("resetRd1", 32'(readData1Out), 32'h0000);
    @(negedge clk);
    reset = 1'b1;

    // ALU reg reading R0
    applyStimulus(16'h2000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("aluRegCtrl", 32'(controlOut), 32'h081);
    checkOutput("aluRegRd1", 32'(readData1Out), 32'h0000);

    // Write R3 then LOAD reading it
    applyStimulus(16'h0000, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(mkInstr(3'd3, 3'd3, 3'd5, 3'd0, 3'd2), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("loadCtrl", 32'(controlOut), 32'h382);
    checkOutput("loadRd1", 32'(readData1Out), 32'hBEEF);
    checkOutput("loadWadd", 32'(writeAddOut), 32'd5);
    checkOutput("loadFunc", 32'(functionOut), 32'd2);

    // Same-cycle bypass on Rsrc2
    applyStimulus(mkInstr(3'd1, 3'd0, 3'd1, 3'd2, 3'd0), 1'b1, 3'd2, 16'h1234, 1'b0, 1'b0);
    checkOutput("bypassRd2", 32'(readData2Out), 32'h1234);
    checkOutput("bypassRd1", 32'(readData1Out), 32'h0000);

    // Asynchronous reset mid-operation, with an ignored write while low
    #3;
    reset = 1'b0;
    #1;
    checkOutput("asyncCtrl", 32'(controlOut), 32'h000);
    checkOutput("asyncRd2", 32'(readData2Out), 32'h0000);
    checkOutput("asyncWadd", 32'(writeAddOut), 32'd0);
    applyStimulus(16'h0000, 1'b1, 3'd4, 16'hAAAA, 1'b0, 1'b0);
    writeEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(mkInstr(3'd1, 3'd3, 3'd0, 3'd4, 3'd0), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("clearedR3", 32'(readData1Out), 32'h0000);
    checkOutput("ignoredR4", 32'(readData2Out), 32'h0000);

    // Decode sweep
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mkInstr(sweepType[i], 3'd0, 3'd0, 3'd0, sweepFunc[i]),
                    1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("sweepCtrl%0d", i), 32'(controlOut), 32'(sweepCtrl[i]));
    end

    // Stall holds outputs; writeback during stall still lands
    applyStimulus(mkInstr(3'd2, 3'd1, 3'd6, 3'd2, 3'd5), 1'b1, 3'd1, 16'h0011, 1'b0, 1'b0);
    checkOutput("preStallCtrl", 32'(controlOut), 32'h083);
    checkOutput("preStallRd1", 32'(readData1Out), 32'h0011);
    applyStimulus(mkInstr(3'd3, 3'd0, 3'd2, 3'd0, 3'd1), 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("stall1Ctrl", 32'(controlOut), 32'h083);
    checkOutput("stall1Wadd", 32'(writeAddOut), 32'd6);
    applyStimulus(mkInstr(3'd3, 3'd0, 3'd2, 3'd0, 3'd1), 1'b1, 3'd5, 16'h5555, 1'b1, 1'b0);
    checkOutput("stall2Ctrl", 32'(controlOut), 32'h083);
    checkOutput("stall2Rd1", 32'(readData1Out), 32'h0011);
    checkOutput("stall2Func", 32'(functionOut), 32'd5);
    applyStimulus(mkInstr(3'd1, 3'd5, 3'd0, 3'd0, 3'd0), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("postStallCtrl", 32'(controlOut), 32'h081);
    checkOutput("postStallRd1", 32'(readData1Out), 32'h5555);

    // Flush: bubble in control, data still loads
    applyStimulus(mkInstr(3'd4, 3'd1, 3'd3, 3'd0, 3'd7), 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("flushCtrl", 32'(controlOut), 32'h000);
    checkOutput("flushRd1", 32'(readData1Out), 32'h0011);
    checkOutput("flushWadd", 32'(writeAddOut), 32'd3);
    checkOutput("flushFunc", 32'(functionOut), 32'd7);

    // Flush beats stall
    applyStimulus(mkInstr(3'd5, 3'd0, 3'd0, 3'd0, 3'd0), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("branchCtrl", 32'(controlOut), 32'h040);
    applyStimulus(mkInstr(3'd1, 3'd1, 3'd4, 3'd0, 3'd1), 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("flushStallCtrl", 32'(controlOut), 32'h000);
    checkOutput("flushStallWadd", 32'(writeAddOut), 32'd4);
    checkOutput("flushStallFunc", 32'(functionOut), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
